// File: rtl/bf_loop_jumper_pkg.sv
// Shared opcode constants and jumper FSM state encoding for the bracket-jump datapath.
package bf_pkg;
  localparam logic [3:0] OP_HALT   = 4'h0;
  localparam logic [3:0] OP_INC_DP = 4'h1;
  localparam logic [3:0] OP_DEC_DP = 4'h2;
  localparam logic [3:0] OP_INC_D  = 4'h3;
  localparam logic [3:0] OP_DEC_D  = 4'h4;
  localparam logic [3:0] OP_OUT    = 4'h5;
  localparam logic [3:0] OP_IN     = 4'h6;
  localparam logic [3:0] OP_LBR    = 4'h7;
  localparam logic [3:0] OP_RBR    = 4'h8;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_STEP  = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
  localparam state_t ST_FAIL  = 3'd5;
endpackage

// File: rtl/bf_loop_jumper_if.sv
// Handshake between main control (master) and the loop jumper (slave).
interface bf_loop_jumper_if #(
  parameter int PC_W    = 16,
  parameter int OP_W    = 4,
  parameter int DEPTH_W = 8
);
  logic               start;
  logic               dir;
  logic [PC_W-1:0]    pc_in;
  logic [OP_W-1:0]    op_in;
  logic               pc_ld;
  logic               pc_dec_inc;
  logic               busy;
  logic               done;
  logic               err;
  logic [DEPTH_W-1:0] depth;

  modport master (
    output start, dir, pc_in, op_in,
    input  pc_ld, pc_dec_inc, busy, done, err, depth
  );
  modport slave (
    input  start, dir, pc_in, op_in,
    output pc_ld, pc_dec_inc, busy, done, err, depth
  );
endinterface

// File: rtl/bf_loop_jumper.sv
// Walks the PC one instruction at a time to the matching bracket, tracking nesting depth.
module bf_loop_jumper
  import bf_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int OP_W    = 4,
  parameter int DEPTH_W = 8,
  parameter int MEM_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  bf_loop_jumper_if.slave  bus
);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

  state_t             r_state;
  logic               r_dir;
  logic [DEPTH_W-1:0] r_depth;
  logic [LAT_W-1:0]   r_lat;

  state_t             w_state_nxt;
  logic [DEPTH_W-1:0] w_depth_nxt;
  logic [LAT_W-1:0]   w_lat_nxt;
  logic [PC_W-1:0]    w_pc;
  logic [OP_W-1:0]    w_op;
  logic [OP_W-1:0]    w_open;
  logic [OP_W-1:0]    w_close;
  logic               w_at_edge;

  assign w_pc    = bus.pc_in;
  assign w_op    = bus.op_in;
  // Backward scans treat ']' as the nesting opener and '[' as the closer.
  assign w_open  = r_dir ? OP_W'(OP_RBR) : OP_W'(OP_LBR);
  assign w_close = r_dir ? OP_W'(OP_LBR) : OP_W'(OP_RBR);
  assign w_at_edge = r_dir ? (w_pc == '0) : (w_pc == {PC_W{1'b1}});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_depth <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_depth <= w_depth_nxt;
      r_lat   <= w_lat_nxt;
      if (r_state == ST_IDLE && bus.start) r_dir <= bus.dir;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_depth_nxt = r_depth;
    w_lat_nxt   = r_lat;
    case (r_state)
      ST_IDLE: if (bus.start) begin
        w_state_nxt = ST_STEP;
        w_depth_nxt = '0;
      end
      ST_STEP: if (w_at_edge) w_state_nxt = ST_FAIL;
               else begin
                 w_state_nxt = ST_WAIT;
                 w_lat_nxt   = '0;
               end
      ST_WAIT: if (r_lat == LAT_W'(MEM_LAT - 1)) w_state_nxt = ST_CHECK;
               else w_lat_nxt = r_lat + LAT_W'(1);
      ST_CHECK: begin
        w_state_nxt = ST_STEP;
        if (w_op == OP_W'(OP_HALT)) w_state_nxt = ST_FAIL;
        else if (w_op == w_open) begin
          if (r_depth == DEPTH_MAX) w_state_nxt = ST_FAIL;
          else w_depth_nxt = r_depth + DEPTH_W'(1);
        end else if (w_op == w_close) begin
          if (r_depth == '0) w_state_nxt = ST_DONE;
          else w_depth_nxt = r_depth - DEPTH_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (r_state == ST_STEP) || (r_state == ST_WAIT) || (r_state == ST_CHECK);
    bus.pc_ld      = (r_state == ST_STEP) && !w_at_edge;
    bus.pc_dec_inc = bus.busy ? ~r_dir : 1'b1;
    bus.done       = (r_state == ST_DONE);
    bus.err        = (r_state == ST_FAIL);
    bus.depth      = r_depth;
  end
endmodule
